// File: rtl/fft_r22sdf_bf_stage_pkg.sv
// Shared constants and elaboration-time helpers for the radix-2^2 SDF stage pair.
package fft_r22sdf_bf_stage_pkg;

  localparam int SRL_MAX_DEPTH = 32;

  function automatic int stage_d1(input int fft_n, input int stage);
    return fft_n >> (32'sd2 * stage + 32'sd1);
  endfunction

  function automatic int stage_d2(input int fft_n, input int stage);
    return fft_n >> (32'sd2 * stage + 32'sd2);
  endfunction

  function automatic int stage_lat(input int fft_n, input int stage);
    return stage_d1(fft_n, stage) + stage_d2(fft_n, stage) + 32'sd2;
  endfunction

  function automatic int bf1_bit_idx(input int nlog2, input int stage);
    return nlog2 - 32'sd1 - 32'sd2 * stage;
  endfunction

  function automatic int bf2_bit_idx(input int nlog2, input int stage);
    return nlog2 - 32'sd2 - 32'sd2 * stage;
  endfunction

endpackage

// File: rtl/fft_r22sdf_bf_stage_delay.sv
// Enable-gated fixed delay: shift registers for short depths, wrapping-pointer RAM otherwise.
module fft_r22sdf_bf_stage_delay
  import fft_r22sdf_bf_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  generate
    if (DEPTH <= SRL_MAX_DEPTH) begin : g_srl
      logic [WIDTH-1:0] sr_q [DEPTH];
      logic             unused_rst_s;
      assign unused_rst_s = rst_i;

      always_ff @(posedge clk_i) begin
        if (en_i) begin
          sr_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end

      assign q_o = sr_q[DEPTH-1];
    end else begin : g_ram
      localparam int AW = $clog2(DEPTH);
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [AW-1:0]    ptr_q;

      // Read and write share one pointer, so the head is the entry written DEPTH pushes ago.
      always_ff @(posedge clk_i) begin
        if (en_i) begin
          mem_q[ptr_q] <= d_i;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          ptr_q <= '0;
        end else if (en_i) begin
          ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end else begin
          ptr_q <= ptr_q;
        end
      end

      assign q_o = mem_q[ptr_q];
    end
  endgenerate

endmodule

// File: rtl/fft_r22sdf_bf_stage.sv
// Radix-2^2 SDF stage pair: BF I, trivial -j rotation, BF II, each with a feedback delay.
// Full-precision datapath (one bit of growth per butterfly); all state advances on valid_i.
module fft_r22sdf_bf_stage
  import fft_r22sdf_bf_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_N      = 1024,
  parameter int NLOG2      = 10,
  parameter int STAGE      = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [NLOG2-1:0]             ctr_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  output logic                         valid_o,
  output logic [NLOG2-1:0]             ctr_o,
  output logic signed [DATA_WIDTH+1:0] z_re_o,
  output logic signed [DATA_WIDTH+1:0] z_im_o
);
  localparam int D1  = stage_d1(FFT_N, STAGE);
  localparam int D2  = stage_d2(FFT_N, STAGE);
  localparam int LAT = stage_lat(FFT_N, STAGE);
  localparam int SB  = bf1_bit_idx(NLOG2, STAGE);
  localparam int TB  = bf2_bit_idx(NLOG2, STAGE);
  localparam int W1  = DATA_WIDTH + 1;
  localparam int W2  = DATA_WIDTH + 2;
  localparam int FW  = $clog2(LAT + 1);

  logic signed [W1-1:0] x_re_s, x_im_s, h1_re_s, h1_im_s;
  logic signed [W1-1:0] b1_re_s, b1_im_s, f1_re_s, f1_im_s;
  logic signed [W1-1:0] p_re_q, p_im_q;
  logic signed [W2-1:0] y_re_s, y_im_s, r_re_s, r_im_s, h2_re_s, h2_im_s;
  logic signed [W2-1:0] b2_re_s, b2_im_s, f2_re_s, f2_im_s;
  logic signed [W2-1:0] z_re_q, z_im_q;
  logic [NLOG2-1:0]     c2_s, c3_s, ctr_o_q;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 primed_q, primed_d, valid_d, valid_o_q;

  assign x_re_s = {x_re_i[DATA_WIDTH-1], x_re_i};
  assign x_im_s = {x_im_i[DATA_WIDTH-1], x_im_i};

  fft_r22sdf_bf_stage_delay #(.WIDTH(W1), .DEPTH(D1)) u_d1_re (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(f1_re_s), .q_o(h1_re_s));
  fft_r22sdf_bf_stage_delay #(.WIDTH(W1), .DEPTH(D1)) u_d1_im (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(f1_im_s), .q_o(h1_im_s));

  always_comb begin
    b1_re_s = h1_re_s;
    b1_im_s = h1_im_s;
    f1_re_s = x_re_s;
    f1_im_s = x_im_s;
    if (ctr_i[SB]) begin
      b1_re_s = h1_re_s + x_re_s;
      b1_im_s = h1_im_s + x_im_s;
      f1_re_s = h1_re_s - x_re_s;
      f1_im_s = h1_im_s - x_im_s;
    end else begin
      b1_re_s = h1_re_s;
      b1_im_s = h1_im_s;
      f1_re_s = x_re_s;
      f1_im_s = x_im_s;
    end
  end

  // c2 lines up with the BF I pipeline register; c3 with the BF II output register.
  fft_r22sdf_bf_stage_delay #(.WIDTH(NLOG2), .DEPTH(D1 + 1)) u_c2 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(ctr_i), .q_o(c2_s));
  fft_r22sdf_bf_stage_delay #(.WIDTH(NLOG2), .DEPTH(D2)) u_c3 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(c2_s), .q_o(c3_s));

  assign y_re_s = {p_re_q[W1-1], p_re_q};
  assign y_im_s = {p_im_q[W1-1], p_im_q};

  // Rotate in the wider format so negating the most negative BF I value cannot wrap.
  always_comb begin
    r_re_s = y_re_s;
    r_im_s = y_im_s;
    if (c2_s[SB] && c2_s[TB]) begin
      r_re_s = y_im_s;
      r_im_s = -y_re_s;
    end else begin
      r_re_s = y_re_s;
      r_im_s = y_im_s;
    end
  end

  fft_r22sdf_bf_stage_delay #(.WIDTH(W2), .DEPTH(D2)) u_d2_re (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(f2_re_s), .q_o(h2_re_s));
  fft_r22sdf_bf_stage_delay #(.WIDTH(W2), .DEPTH(D2)) u_d2_im (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(valid_i), .d_i(f2_im_s), .q_o(h2_im_s));

  always_comb begin
    b2_re_s = h2_re_s;
    b2_im_s = h2_im_s;
    f2_re_s = r_re_s;
    f2_im_s = r_im_s;
    if (c2_s[TB]) begin
      b2_re_s = h2_re_s + r_re_s;
      b2_im_s = h2_im_s + r_im_s;
      f2_re_s = h2_re_s - r_re_s;
      f2_im_s = h2_im_s - r_im_s;
    end else begin
      b2_re_s = h2_re_s;
      b2_im_s = h2_im_s;
      f2_re_s = r_re_s;
      f2_im_s = r_im_s;
    end
  end

  // Fill counter stops once LAT-1 samples are in; the LAT-th accepted sample emits frame position 0.
  always_comb begin
    primed_d = primed_q || (fill_q == FW'(LAT - 1));
    fill_d   = fill_q;
    valid_d  = 1'b0;
    if (valid_i) begin
      valid_d = primed_d;
      fill_d  = primed_d ? fill_q : fill_q + 1'b1;
    end else begin
      valid_d = 1'b0;
      fill_d  = fill_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_re_q    <= '0;
      p_im_q    <= '0;
      z_re_q    <= '0;
      z_im_q    <= '0;
      ctr_o_q   <= '0;
      fill_q    <= '0;
      primed_q  <= 1'b0;
      valid_o_q <= 1'b0;
    end else if (valid_i) begin
      p_re_q    <= b1_re_s;
      p_im_q    <= b1_im_s;
      z_re_q    <= b2_re_s;
      z_im_q    <= b2_im_s;
      ctr_o_q   <= c3_s;
      fill_q    <= fill_d;
      primed_q  <= primed_d;
      valid_o_q <= valid_d;
    end else begin
      valid_o_q <= 1'b0;
    end
  end

  assign valid_o = valid_o_q;
  assign ctr_o   = ctr_o_q;
  assign z_re_o  = z_re_q;
  assign z_im_o  = z_im_q;

endmodule

// File: tb/tb_fft_r22sdf_bf_stage.sv
// Directed, table-driven bench for fft_r22sdf_bf_stage at N=16, STAGE=0 (LAT=14).
module tb_fft_r22sdf_bf_stage;
  localparam int DW = 25;
  localparam int NL = 4;

  logic                 clk = 1'b0;
  logic                 rst_i, valid_i;
  logic [NL-1:0]        ctr_i;
  logic signed [DW-1:0] x_re_i, x_im_i;
  logic                 valid_o;
  logic [NL-1:0]        ctr_o;
  logic signed [DW+1:0] z_re_o, z_im_o;

  always #5 clk = ~clk;

  fft_r22sdf_bf_stage #(.DATA_WIDTH(DW), .FFT_N(16), .NLOG2(NL), .STAGE(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ctr_i(ctr_i),
    .x_re_i(x_re_i), .x_im_i(x_im_i), .valid_o(valid_o), .ctr_o(ctr_o),
    .z_re_o(z_re_o), .z_im_o(z_im_o));

  typedef struct {
    string name;
    bit    stall;
    int    in_re[16];
    int    exp_re[16];
    int    exp_im[16];
  } vec_t;

  vec_t  vecs[6];
  int    q_re[$], q_im[$], q_ctr[$];
  string q_nm[$];
  int    checks = 0, errors = 0;
  bit    hold_chk = 1'b0, have_last = 1'b0;
  int    last_re, last_im, last_ctr;
  int    early;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit v, input int c, input int re, input int im);
    valid_i = v;
    ctr_i   = NL'(c);
    x_re_i  = DW'(re);
    x_im_i  = DW'(im);
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int vi);
    for (int p = 0; p < 16; p++) begin
      q_re.push_back(vecs[vi].exp_re[p]);
      q_im.push_back(vecs[vi].exp_im[p]);
      q_ctr.push_back(p);
      q_nm.push_back(vecs[vi].name);
    end
  endtask

  task automatic feed_frame(input int vi, input bit push);
    if (push) push_exp(vi);
    for (int p = 0; p < 16; p++) begin
      if (vecs[vi].stall) step(1'b0, p, 12345, -777);
      step(1'b1, p, vecs[vi].in_re[p], 0);
    end
  endtask

  // Unchecked frame used to drain the pipeline; x[3]=500 leaves nonzero outputs behind.
  task automatic feed_flush(input bit stall);
    for (int p = 0; p < 16; p++) begin
      if (stall) step(1'b0, p, 12345, -777);
      step(1'b1, p, (p == 3) ? 500 : 0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (valid_o === 1'b1 && q_re.size() > 0) begin
      check($sformatf("%s p%0d re", q_nm[0], q_ctr[0]), int'(z_re_o), q_re[0]);
      check($sformatf("%s p%0d im", q_nm[0], q_ctr[0]), int'(z_im_o), q_im[0]);
      check($sformatf("%s p%0d ctr", q_nm[0], q_ctr[0]), int'(ctr_o), q_ctr[0]);
      last_re  = q_re.pop_front();
      last_im  = q_im.pop_front();
      last_ctr = q_ctr.pop_front();
      void'(q_nm.pop_front());
      have_last = 1'b1;
    end else if (hold_chk && have_last && q_re.size() > 0) begin
      check("hold re", int'(z_re_o), last_re);
      check("hold im", int'(z_im_o), last_im);
      check("hold ctr", int'(ctr_o), last_ctr);
    end
  end

  initial begin
    for (int i = 0; i < 6; i++) begin
      vecs[i].stall = 1'b0;
      for (int p = 0; p < 16; p++) begin
        vecs[i].in_re[p]  = 0;
        vecs[i].exp_re[p] = 0;
        vecs[i].exp_im[p] = 0;
      end
    end
    vecs[0].name = "impulse";
    vecs[0].in_re[0] = 1000;
    vecs[0].exp_re[0] = 1000; vecs[0].exp_re[4] = 1000;
    vecs[0].exp_re[8] = 1000; vecs[0].exp_re[12] = 1000;
    vecs[1].name = "dc";
    for (int p = 0; p < 16; p++) vecs[1].in_re[p] = 100;
    for (int p = 0; p < 4; p++) vecs[1].exp_re[p] = 400;
    vecs[2].name = "jpath";
    vecs[2].in_re[4] = 100;
    vecs[2].exp_re[0] = 100;  vecs[2].exp_re[4] = -100;
    vecs[2].exp_im[8] = -100; vecs[2].exp_im[12] = 100;
    vecs[3].name = "grow_pos";
    for (int p = 0; p < 16; p++) vecs[3].in_re[p] = 16777215;
    for (int p = 0; p < 4; p++) vecs[3].exp_re[p] = 67108860;
    vecs[4].name = "grow_neg";
    for (int p = 0; p < 16; p++) vecs[4].in_re[p] = -16777216;
    for (int p = 0; p < 4; p++) vecs[4].exp_re[p] = -67108864;
    vecs[5] = vecs[2];
    vecs[5].name  = "stall";
    vecs[5].stall = 1'b1;

    rst_i = 1'b1;
    step(1'b0, 0, 0, 0);
    step(1'b0, 0, 0, 0);
    check("reset valid_o", int'(valid_o), 0);
    check("reset ctr_o", int'(ctr_o), 0);
    check("reset z_re", int'(z_re_o), 0);
    check("reset z_im", int'(z_im_o), 0);
    rst_i = 1'b0;

    // Back-to-back frames; the last one runs with valid_i low every other cycle.
    for (int i = 0; i < 6; i++) begin
      hold_chk = vecs[i].stall;
      feed_frame(i, 1'b1);
    end
    feed_flush(1'b1);
    hold_chk = 1'b0;
    check("drain main", q_re.size(), 0);

    // Reset at sample 5 of an impulse frame, then restart the frame from ctr 0.
    for (int p = 0; p < 5; p++) step(1'b1, p, vecs[0].in_re[p], 0);
    rst_i = 1'b1;
    step(1'b1, 5, 0, 0);
    rst_i = 1'b0;
    check("midrst valid_o", int'(valid_o), 0);
    check("midrst ctr_o", int'(ctr_o), 0);
    check("midrst z_re", int'(z_re_o), 0);
    check("midrst z_im", int'(z_im_o), 0);
    q_re.delete(); q_im.delete(); q_ctr.delete(); q_nm.delete();
    push_exp(0);
    early = 0;
    for (int p = 0; p < 16; p++) begin
      step(1'b1, p, vecs[0].in_re[p], 0);
      if (p < 13 && valid_o !== 1'b0) early++;
      if (p == 13) check("reprime valid_o", int'(valid_o), 1);
    end
    check("reprime quiet", early, 0);
    feed_flush(1'b0);
    check("drain reset", q_re.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
